// File: rtl/dfs_pkg.sv
// Types and constants shared by the DFS request channel.
// Requesters multiply MHz by FREQ_SCALE_X8 before driving a frequency word.
package dfs_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIVIDE,
    S_ROUND,
    S_PROGRAM,
    S_WAIT_LOCK,
    S_ACK
  } dfs_state_e;

  localparam int DIV_W_DEF = 8;
  typedef logic [DIV_W_DEF-1:0] div_t;

  localparam div_t DIV_MIN_DEF   = 8'd2;
  localparam div_t DIV_MAX_DEF   = 8'd255;
  localparam int   FREQ_SCALE_X8 = 8;

endpackage

// File: rtl/dfs_seq_udiv.sv
// Restoring unsigned divider: start loads operands, one quotient bit per cycle, W cycles,
// then done_o pulses for one cycle; quotient and remainder hold until the next start.
module dfs_seq_udiv #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [W-1:0] quo_o,
  output logic [W:0]   rem_o
);

  localparam int CW = $clog2(W + 1);

  logic [W:0]    rem_q, rem_d, shift;
  logic [W-1:0]  quo_q, dvsr_q;
  logic [CW-1:0] cnt_q;
  logic          done_q, take;

  // quo_q doubles as the dividend shift register: dividend bits leave the top, quotient bits enter the bottom
  assign shift = {rem_q[W-1:0], quo_q[W-1]};
  assign take  = (shift >= {1'b0, dvsr_q});
  assign rem_d = take ? (shift - {1'b0, dvsr_q}) : shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= '0;
        quo_q  <= dividend_i;
        dvsr_q <= divisor_i;
        cnt_q  <= CW'(W);
      end else if (cnt_q != '0) begin
        rem_q  <= rem_d;
        quo_q  <= {quo_q[W-2:0], take};
        cnt_q  <= cnt_q - CW'(1);
        done_q <= (cnt_q == CW'(1));
      end
    end
  end

  assign done_o = done_q;
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/dfs_freq_responder.sv
// DFS responder: turns a frequency word into a clamped ceil(VCO/req) divide ratio, programs the
// clock generator over valid/ready, acks once locked; strobes while busy land in a last-wins slot.
module dfs_freq_responder
  import dfs_pkg::*;
#(
  parameter int DATA_WIDTH   = 13,
  parameter int VCO_FREQ_X8  = 960 * FREQ_SCALE_X8,
  parameter int DIV_WIDTH    = DIV_W_DEF,
  parameter int DIV_MIN      = int'(DIV_MIN_DEF),
  parameter int DIV_MAX      = int'(DIV_MAX_DEF),
  parameter int DIV_RST      = 16,
  parameter int LOCK_BLANK   = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_en_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  req_ack_o,
  output logic                  req_err_o,
  output logic                  cfg_valid_o,
  output logic [DIV_WIDTH-1:0]  cfg_div_o,
  input  logic                  cfg_ready_i,
  input  logic                  lock_i,
  output logic [DIV_WIDTH-1:0]  cur_div_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(LOCK_BLANK + LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      BLANK_C = CNT_W'(LOCK_BLANK);
  localparam logic [CNT_W-1:0]      LAST_C  = CNT_W'(LOCK_BLANK + LOCK_TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] VCO_C   = DATA_WIDTH'(VCO_FREQ_X8);
  localparam logic [DATA_WIDTH:0]   MIN_C   = (DATA_WIDTH + 1)'(DIV_MIN);
  localparam logic [DATA_WIDTH:0]   MAX_C   = (DATA_WIDTH + 1)'(DIV_MAX);

  dfs_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] req_q, pend_q, word, quo;
  logic [DATA_WIDTH:0]   rem, q_ceil;
  logic [DIV_WIDTH-1:0]  div_clamp, cfg_div_q, cur_div_q;
  logic [CNT_W-1:0]      lock_cnt_q;
  logic                  pend_vld_q, err_q, take, div_done, same, lock_ok, lock_tmo;

  // A fresh strobe beats a queued word when both are present in S_IDLE
  assign take = (state_q == S_IDLE) && (req_en_i || pend_vld_q);
  assign word = req_en_i ? req_data_i : pend_q;

  dfs_seq_udiv #(.W(DATA_WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (take),
    .dividend_i(VCO_C),
    .divisor_i (word),
    .done_o    (div_done),
    .quo_o     (quo),
    .rem_o     (rem)
  );

  assign q_ceil = {1'b0, quo} + {{DATA_WIDTH{1'b0}}, (rem != '0)};

  always_comb begin
    div_clamp = DIV_WIDTH'(DIV_MAX);
    if (req_q != '0) begin
      if (q_ceil < MIN_C)       div_clamp = DIV_WIDTH'(DIV_MIN);
      else if (q_ceil <= MAX_C) div_clamp = q_ceil[DIV_WIDTH-1:0];
    end
  end

  assign same     = (div_clamp == cur_div_q);
  assign lock_ok  = lock_i && (lock_cnt_q >= BLANK_C);
  assign lock_tmo = (lock_cnt_q == LAST_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (take) state_d = S_DIVIDE;
      S_DIVIDE:    if (div_done) state_d = S_ROUND;
      S_ROUND:     state_d = same ? S_ACK : S_PROGRAM;
      S_PROGRAM:   if (cfg_ready_i) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: if (lock_ok || lock_tmo) state_d = S_ACK;
      S_ACK:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ack_o   = (state_q == S_ACK);
    req_err_o   = (state_q == S_ACK) && err_q;
    cfg_valid_o = (state_q == S_PROGRAM);
    busy_o      = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cfg_div_q  <= DIV_WIDTH'(DIV_RST);
      cur_div_q  <= DIV_WIDTH'(DIV_RST);
      lock_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (take) begin
        req_q      <= word;
        pend_vld_q <= 1'b0;
      end else if (req_en_i) begin
        pend_q     <= req_data_i;
        pend_vld_q <= 1'b1;
      end
      if (state_q == S_ROUND) begin
        err_q <= 1'b0;
        if (!same) cfg_div_q <= div_clamp;
      end
      // Lock wins over timeout when both land in the same cycle
      if (state_q == S_PROGRAM && cfg_ready_i) begin
        lock_cnt_q <= '0;
      end else if (state_q == S_WAIT_LOCK) begin
        lock_cnt_q <= lock_cnt_q + CNT_W'(1);
        if (lock_ok)       cur_div_q <= cfg_div_q;
        else if (lock_tmo) err_q     <= 1'b1;
      end
    end
  end

  assign cfg_div_o = cfg_div_q;
  assign cur_div_o = cur_div_q;

endmodule
